// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the VGA draw arbiter: FSM state encoding,
// default pixel-bus widths and screen bounds, plus a small width helper.
package vga_draw_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   localparam int DEF_X_W  = 8;
   localparam int DEF_Y_W  = 7;
   localparam int DEF_C_W  = 9;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   // Index width that stays legal for a single-entry range.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_draw_arbiter_rr_picker.sv
// Combinational winner selection for the draw arbiter.
// RR_MODE=0: lowest requesting index wins. RR_MODE=1: search starts at ptr
// and wraps, so the most recent grantee drops to lowest priority.
module vga_draw_arbiter_rr_picker
   import vga_draw_arbiter_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int RR_MODE = 1,
   parameter int IW      = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   winner,
   output logic            valid
);

   // Scan from the far end back to the start so the closest requester to
   // the search origin is the last (and therefore final) assignment.
   always_comb begin
      int base;
      int idx;
      valid  = |req;
      winner = '0;
      base   = (RR_MODE != 0) ? int'(ptr) : 0;
      idx    = 0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = (base + k) % N_CH;
         if (req[idx]) winner = IW'(idx);
      end
   end

endmodule

// File: rtl/vga_draw_arbiter.sv
// N-channel arbiter/mux between drawing engines and the single vga_adapter.
// A channel owns the pixel bus from grant until done_in or request drop;
// its x/y/colour/plot stream is registered onto one output bus.
// Optional feature: define VGA_ARB_TIMEOUT_EN to force release of a grant
// that sees no pixel for TIMEOUT_CYC cycles (timeout output pulses once).
module vga_draw_arbiter
   import vga_draw_arbiter_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int X_W         = DEF_X_W,
   parameter int Y_W         = DEF_Y_W,
   parameter int C_W         = DEF_C_W,
   parameter int RR_MODE     = 1,
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         req,
   input  logic [N_CH*X_W-1:0]     x_in,
   input  logic [N_CH*Y_W-1:0]     y_in,
   input  logic [N_CH*C_W-1:0]     colour_in,
   input  logic [N_CH-1:0]         plot_in,
   input  logic [N_CH-1:0]         done_in,
   output logic [N_CH-1:0]         gnt,
   output logic [X_W-1:0]          x,
   output logic [Y_W-1:0]          y,
   output logic [C_W-1:0]          colour,
   output logic                    plot,
   output logic                    busy,
   output logic [$clog2(N_CH)-1:0] active_ch,
   output logic                    timeout
);

   localparam int IW = $clog2(N_CH);

   logic [N_CH-1:0][X_W-1:0] x_ch;
   logic [N_CH-1:0][Y_W-1:0] y_ch;
   logic [N_CH-1:0][C_W-1:0] c_ch;

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_unpack
         assign x_ch[i] = x_in[i*X_W +: X_W];
         assign y_ch[i] = y_in[i*Y_W +: Y_W];
         assign c_ch[i] = colour_in[i*C_W +: C_W];
      end
   endgenerate

   arb_state_e    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] winner;
   logic          win_vld;
   logic          plot_g;
   logic          fin_g;
   logic          expire;

   // active_ch holds the grantee index for the whole grant, so it doubles
   // as the mux select for the granted channel's signals.
   assign plot_g = plot_in[active_ch];
   assign fin_g  = done_in[active_ch] | ~req[active_ch];

   vga_draw_arbiter_rr_picker #(
      .N_CH    (N_CH),
      .RR_MODE (RR_MODE),
      .IW      (IW)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .winner (winner),
      .valid  (win_vld)
   );

`ifdef VGA_ARB_TIMEOUT_EN
   localparam int TW = idx_w(TIMEOUT_CYC);
   logic [TW-1:0] to_cnt;

   assign expire = (state == ST_GRANT) && !plot_g && (to_cnt == TW'(TIMEOUT_CYC - 1));

   // Idle-cycle counter for the current grant; any granted pixel restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state == ST_IDLE && win_vld) begin
         to_cnt <= '0;
      end else if (state == ST_GRANT) begin
         if (plot_g)       to_cnt <= '0;
         else if (!expire) to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   logic unused_tc;
   assign unused_tc = (TIMEOUT_CYC > 0);
   assign expire    = 1'b0;
`endif

   // Grant FSM with registered grant, status and pixel-bus outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         gnt       <= '0;
         active_ch <= '0;
         busy      <= 1'b0;
         x         <= '0;
         y         <= '0;
         colour    <= '0;
         plot      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         plot    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_vld) begin
                  gnt       <= N_CH'(1) << winner;
                  active_ch <= winner;
                  ptr       <= (winner == IW'(N_CH - 1)) ? '0 : winner + 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // The pixel presented alongside done/req-drop still retires.
               if (plot_g) begin
                  x      <= x_ch[active_ch];
                  y      <= y_ch[active_ch];
                  colour <= c_ch[active_ch];
                  plot   <= 1'b1;
               end
               if (fin_g || expire) begin
                  gnt     <= '0;
                  timeout <= expire & ~fin_g;
                  state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Bench for vga_draw_arbiter: a round-robin and a fixed-priority instance
// share one stimulus; a cycle model of each is compared every cycle, and
// directed checks pin literal values from the scenarios.
module tb_vga_draw_arbiter;

   localparam int N  = 4;
   localparam int TC = 16;

   logic        clk;
   logic        reset;
   logic [3:0]  req, plot_in, done_in;
   logic [31:0] x_in;
   logic [27:0] y_in;
   logic [35:0] colour_in;

   logic [3:0] gnt_r, gnt_f;
   logic [7:0] x_r, x_f;
   logic [6:0] y_r, y_f;
   logic [8:0] c_r, c_f;
   logic       plot_r, plot_f, busy_r, busy_f, to_r, to_f;
   logic [1:0] act_r, act_f;

   int total = 0;
   int bad   = 0;

   vga_draw_arbiter #(.N_CH(4), .X_W(8), .Y_W(7), .C_W(9), .RR_MODE(1), .TIMEOUT_CYC(TC)) u_rr (
      .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .plot_in(plot_in), .done_in(done_in), .gnt(gnt_r), .x(x_r), .y(y_r), .colour(c_r),
      .plot(plot_r), .busy(busy_r), .active_ch(act_r), .timeout(to_r));

   vga_draw_arbiter #(.N_CH(4), .X_W(8), .Y_W(7), .C_W(9), .RR_MODE(0), .TIMEOUT_CYC(TC)) u_fx (
      .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .plot_in(plot_in), .done_in(done_in), .gnt(gnt_f), .x(x_f), .y(y_f), .colour(c_f),
      .plot(plot_f), .busy(busy_f), .active_ch(act_f), .timeout(to_f));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   // ---------------- model ----------------
   // owner/cool describe who holds the bus and how many cycles remain
   // before a fresh arbitration may happen.
   typedef struct packed {
      logic        own_v;
      logic [3:0]  own;
      logic [3:0]  cool;
      logic [3:0]  ptr;
      logic [3:0]  last;
      logic [15:0] cnt;
      logic        plot;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [8:0]  c;
      logic        tmo;
   } mdl_t;

   mdl_t m [2];
   bit   armed = 0;

   function automatic mdl_t step(input mdl_t s, input bit rr);
      mdl_t n;
      int   g, base, i;
      bit   fin, ex, found;
      n = s; n.plot = 0; n.tmo = 0;
      fin = 0; ex = 0; found = 0;
      if (s.own_v) begin
         g   = int'(s.own);
         fin = done_in[g] || !req[g];
         if (plot_in[g]) begin
            n.plot = 1; n.cnt = 0;
            n.x = x_in[g*8 +: 8]; n.y = y_in[g*7 +: 7]; n.c = colour_in[g*9 +: 9];
         end
`ifdef VGA_ARB_TIMEOUT_EN
         else if (int'(s.cnt) == TC - 1) ex = 1;
         else n.cnt = s.cnt + 16'd1;
`endif
         if (fin || ex) begin
            n.own_v = 0; n.cool = 4'd1; n.tmo = ex && !fin;
         end
      end else if (s.cool != 0) begin
         n.cool = s.cool - 4'd1;
      end else if (req != 4'd0) begin
         base = rr ? int'(s.ptr) : 0;
         for (int k = 0; k < N; k++) begin
            i = (base + k) % N;
            if (!found && req[i]) begin
               found = 1; n.own_v = 1; n.own = 4'(i); n.last = 4'(i);
               n.cnt = 0; n.ptr = 4'((i + 1) % N);
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m[0]  <= '0;
         m[1]  <= '0;
         armed <= 1;
      end else if (armed) begin
         m[0] <= step(m[0], 1'b1);
         m[1] <= step(m[1], 1'b0);
      end
   end

   task automatic cmp(input string t, input mdl_t e, input logic [3:0] g, input logic [7:0] xv,
                      input logic [6:0] yv, input logic [8:0] cv, input logic p, input logic b,
                      input logic [1:0] a, input logic tv);
      chk({t, ".gnt"},    32'(g),  e.own_v ? (32'd1 << e.own) : 32'd0);
      chk({t, ".x"},      32'(xv), 32'(e.x));
      chk({t, ".y"},      32'(yv), 32'(e.y));
      chk({t, ".colour"}, 32'(cv), 32'(e.c));
      chk({t, ".plot"},   32'(p),  32'(e.plot));
      chk({t, ".busy"},   32'(b),  32'(e.own_v || (e.cool != 0)));
      chk({t, ".active"}, 32'(a),  32'(e.last));
      chk({t, ".timeout"},32'(tv), 32'(e.tmo));
   endtask

   always @(negedge clk) begin
      if (armed) begin
         cmp("rr", m[0], gnt_r, x_r, y_r, c_r, plot_r, busy_r, act_r, to_r);
         cmp("fx", m[1], gnt_f, x_f, y_f, c_f, plot_f, busy_f, act_f, to_f);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_px(input int ch, input int xv, input int yv, input int cv);
      x_in[ch*8 +: 8]      = 8'(xv);
      y_in[ch*7 +: 7]      = 7'(yv);
      colour_in[ch*9 +: 9] = 9'(cv);
   endtask

   task automatic wait_gnt(input string nm);
      int n;
      n = 0;
      while (gnt_r == 4'd0 && n < 20) begin
         tick();
         n++;
      end
      chk(nm, 32'(gnt_r != 4'd0), 32'd1);
   endtask

   logic [3:0] rr_exp [5];
   int         hold_bad, n_on, tmo_cnt;

   initial begin
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset = 1; req = 4'b1111; plot_in = 0; done_in = 0;
      x_in = 0; y_in = 0; colour_in = 0;

      // 1: reset with all requests up
      repeat (3) tick();
      chk("rst_gnt", 32'(gnt_r), 0);
      chk("rst_plot", 32'(plot_r), 0);
      chk("rst_busy", 32'(busy_r), 0);
      chk("rst_act", 32'(act_r), 0);
      reset = 0; req = 0;
      tick();

      // 2: single draw on ch1
      req = 4'b0010;
      tick();
      chk("sd_gnt", 32'(gnt_r), 32'b0010);
      chk("sd_act", 32'(act_r), 1);
      chk("mdl_owner", 32'(m[1].own), 1);
      for (int v = 5; v <= 7; v++) begin
         set_px(1, v, 10, 9'h1FF); plot_in = 4'b0010;
         tick();
         chk("sd_plot", 32'(plot_r), 1);
         chk("sd_x", 32'(x_r), 32'(v));
         chk("sd_y", 32'(y_r), 10);
         chk("sd_c", 32'(c_r), 32'h1FF);
      end
      plot_in = 0; done_in = 4'b0010;
      tick();
      chk("sd_rel_gnt", 32'(gnt_r), 0);
      chk("sd_rel_plot", 32'(plot_r), 0);
      chk("sd_rel_busy", 32'(busy_r), 1);
      chk("sd_hold_x", 32'(x_r), 7);
      done_in = 0; req = 0;
      tick();
      chk("sd_idle_busy", 32'(busy_r), 0);

      // reset in the middle of a grant
      req = 4'b0010;
      tick();
      set_px(1, 33, 3, 3); plot_in = 4'b0010; reset = 1;
      tick();
      chk("mr_plot0", 32'(plot_r), 0);
      chk("mr_gnt0", 32'(gnt_r), 0);
      reset = 0;
      tick();
      chk("mr_plot1", 32'(plot_r), 0);
      chk("mr_gnt1", 32'(gnt_r), 32'b0010);
      plot_in = 0; req = 0;
      tick(); tick();
      reset = 1;
      tick(); tick();
      reset = 0;
      tick();

      // 3: round-robin vs fixed with all channels requesting
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_gnt("rr_wait");
         chk("rr_order", 32'(gnt_r), 32'(rr_exp[k]));
         chk("fx_order", 32'(gnt_f), 32'b0001);
         for (int ch = 0; ch < 4; ch++) set_px(ch, k, k, k);
         plot_in = 4'b1111; done_in = 4'b1111;
         tick();
         plot_in = 0; done_in = 0;
      end
      chk("mdl_rr_ptr", 32'(m[0].ptr), 1);
      req = 0;
      tick(); tick();

      // 4: done and plot together at the screen corner
      req = 4'b0001;
      wait_gnt("dp_wait");
      set_px(0, 159, 119, 9'h0AA); plot_in = 4'b0001; done_in = 4'b0001;
      tick();
      chk("dp_plot", 32'(plot_r), 1);
      chk("dp_x", 32'(x_r), 159);
      chk("dp_y", 32'(y_r), 119);
      chk("dp_gnt", 32'(gnt_r), 0);
      plot_in = 0; done_in = 0; req = 0;
      tick(); tick();

      // 5: isolation of non-granted channel activity
      req = 4'b0100;
      wait_gnt("iso_wait");
      chk("iso_gnt", 32'(gnt_r), 32'b0100);
      chk("iso_gnt_fx", 32'(gnt_f), 32'b0100);
      set_px(0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         set_px(2, 100 + k, 50, 9'h055);
         plot_in = (k % 2 == 0) ? 4'b0100 : 4'b0001;
         done_in = (k == 3) ? 4'b0001 : 4'b0000;
         tick();
         chk("iso_plot", 32'(plot_r), 32'(k % 2 == 0));
         chk("iso_x", 32'(x_r), 32'(100 + k - (k % 2)));
      end
      plot_in = 0; done_in = 4'b0100;
      tick();
      done_in = 0; req = 0;
      tick(); tick();

      // 6: grant with no pixel activity
      req = 4'b1000;
      wait_gnt("to_wait");
      chk("to_gnt", 32'(gnt_r), 32'b1000);
`ifdef VGA_ARB_TIMEOUT_EN
      n_on = 0; tmo_cnt = 0;
      while (gnt_r != 4'd0 && n_on < 100) begin
         if (to_r) tmo_cnt++;
         tick();
         n_on++;
      end
      chk("to_len", 32'(n_on), 16);
      chk("to_pulse", 32'(to_r), 1);
      chk("to_early", 32'(tmo_cnt), 0);
      tick();
      chk("to_once", 32'(to_r), 0);
      req = 0;
`else
      hold_bad = 0;
      repeat (1000) begin
         tick();
         if (gnt_r != 4'b1000 || to_r) hold_bad++;
      end
      chk("hold_bad", 32'(hold_bad), 0);
      chk("hold_gnt", 32'(gnt_r), 32'b1000);
      req = 0;
      tick();
      chk("hold_rel", 32'(gnt_r), 0);
`endif
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
